// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the snoop-bus controller: bus operations, FSM states,
// and a saturating increment used by the optional COH_STATS_EN counters.
package coherence_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2
  } bus_op_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    RESP_WAIT,
    MEM_RD,
    WB,
    DONE
  } bus_state_t;

  localparam int unsigned STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first pending requester at or
// after ptr, wrapping modulo NUM_CORES.
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned IW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [NUM_CORES-1:0] grant
);

  logic [IW-1:0] idx;
  logic          taken;

  // Walk the cores starting at ptr; first pending one wins.
  always_comb begin
    grant = '0;
    taken = 1'b0;
    idx   = ptr;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!taken && req[idx]) begin
        grant[idx] = 1'b1;
        taken      = 1'b1;
      end
      idx = (idx == IW'(NUM_CORES - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Shared snoop-bus controller: arbitrates core misses/upgrades, broadcasts a
// snoop, sources data from a Modified owner or memory, and returns the fill
// with a one-cycle done pulse.
// Optional feature macro: COH_STATS_EN (adds saturating transaction counters).
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned AW        = 13,
  parameter int unsigned DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    core_rd_miss,
  input  logic [NUM_CORES-1:0]    core_wr_miss,
  input  logic [NUM_CORES-1:0]    core_inv,
  input  logic [NUM_CORES*AW-1:0] core_addr,
  output logic [NUM_CORES-1:0]    core_done,
  output logic [DW-1:0]           fill_data,
  output logic [NUM_CORES-1:0]    snoop_req,
  output logic [1:0]              snoop_op,
  output logic [AW-1:0]           snoop_addr,
  input  logic [NUM_CORES-1:0]    snoop_found,
  input  logic [NUM_CORES*DW-1:0] snoop_data,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic [DW-1:0]           mem_rdata,
  input  logic                    mem_rdy
`ifdef COH_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_txn,
  output logic [STAT_W-1:0]       stat_c2c,
  output logic [STAT_W-1:0]       stat_memrd
`endif
);

  localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  bus_state_t     state_q, state_d;
  logic [IW-1:0]  id_q, id_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  bus_op_t        op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic           idle_wait_q, idle_wait_d;

  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] sel;
  logic [NUM_CORES-1:0] found_m;
  logic [IW-1:0]        gidx;
  bus_op_t              gop;
  logic [AW-1:0]        gaddr;
  logic [DW-1:0]        hit_data;
  logic                 hit;

  // Any request type makes a core pending.
  always_comb pending = core_rd_miss | core_wr_miss | core_inv;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES),
    .IW       (IW)
  ) u_arb (
    .req  (pending),
    .ptr  (rr_ptr_q),
    .grant(grant)
  );

  // Decode the granted core: index, bus op by priority, request address.
  always_comb begin
    gidx  = '0;
    gop   = BUS_RD;
    gaddr = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        gidx  = IW'(i);
        gaddr = core_addr[i*AW +: AW];
        if (core_wr_miss[i])  gop = BUS_RDX;
        else if (core_inv[i]) gop = BUS_UPGR;
        else                  gop = BUS_RD;
      end
    end
  end

  // Snoop response: ignore the requester, lowest-index owner wins on multi-hit.
  always_comb begin
    sel         = '0;
    sel[id_q]   = 1'b1;
    found_m     = snoop_found & ~sel;
    hit         = 1'b0;
    hit_data    = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (found_m[i] && !hit) begin
        hit      = 1'b1;
        hit_data = snoop_data[i*DW +: DW];
      end
    end
  end

  // Next-state and Moore outputs of the bus FSM.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    idle_wait_d = 1'b0;
    core_done   = '0;
    fill_data   = '0;
    snoop_req   = '0;
    snoop_op    = '0;
    snoop_addr  = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (!idle_wait_q && (|pending)) begin
          state_d = SNOOP;
          id_d    = gidx;
          op_d    = gop;
          addr_d  = gaddr;
        end
      end
      SNOOP: begin
        snoop_req  = ~sel;
        snoop_op   = op_q;
        snoop_addr = addr_q;
        state_d    = RESP_WAIT;
      end
      RESP_WAIT: begin
        if (op_q == BUS_UPGR) begin
          data_d  = '0;
          state_d = DONE;
        end else if (hit) begin
          data_d  = hit_data;
          state_d = (op_q == BUS_RDX) ? DONE : WB;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        mem_re   = 1'b1;
        mem_addr = addr_q;
        if (mem_rdy) begin
          data_d  = mem_rdata;
          state_d = DONE;
        end
      end
      WB: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        if (mem_rdy) state_d = DONE;
      end
      DONE: begin
        core_done   = sel;
        fill_data   = data_q;
        rr_ptr_d    = (id_q == IW'(NUM_CORES - 1)) ? '0 : id_q + 1'b1;
        idle_wait_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; idle_wait_q blocks the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      op_q        <= BUS_RD;
      addr_q      <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      idle_wait_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      idle_wait_q <= idle_wait_d;
    end
  end

`ifdef COH_STATS_EN
  logic [STAT_W-1:0] stat_txn_q, stat_txn_d;
  logic [STAT_W-1:0] stat_c2c_q, stat_c2c_d;
  logic [STAT_W-1:0] stat_memrd_q, stat_memrd_d;

  // Saturating event counters.
  always_comb begin
    stat_txn_d   = sat_inc(stat_txn_q, state_q == DONE);
    stat_c2c_d   = sat_inc(stat_c2c_q,
                           (state_q == RESP_WAIT) && (op_q != BUS_UPGR) && hit);
    stat_memrd_d = sat_inc(stat_memrd_q, (state_q == MEM_RD) && mem_rdy);
    stat_txn     = stat_txn_q;
    stat_c2c     = stat_c2c_q;
    stat_memrd   = stat_memrd_q;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_txn_q   <= '0;
      stat_c2c_q   <= '0;
      stat_memrd_q <= '0;
    end else begin
      stat_txn_q   <= stat_txn_d;
      stat_c2c_q   <= stat_c2c_d;
      stat_memrd_q <= stat_memrd_d;
    end
  end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl (default build, 2 cores).
module tb_coherence_bus_ctrl;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_rd_miss, core_wr_miss, core_inv;
  logic [N*AW-1:0] core_addr;
  logic [N-1:0]    core_done, snoop_req, snoop_found;
  logic [DW-1:0]   fill_data, mem_wdata, mem_rdata;
  logic [1:0]      snoop_op;
  logic [AW-1:0]   snoop_addr, mem_addr;
  logic [N*DW-1:0] snoop_data;
  logic            mem_re, mem_we, mem_rdy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  coherence_bus_ctrl #(
    .NUM_CORES(N),
    .AW       (AW),
    .DW       (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_rd_miss(core_rd_miss),
    .core_wr_miss(core_wr_miss),
    .core_inv    (core_inv),
    .core_addr   (core_addr),
    .core_done   (core_done),
    .fill_data   (fill_data),
    .snoop_req   (snoop_req),
    .snoop_op    (snoop_op),
    .snoop_addr  (snoop_addr),
    .snoop_found (snoop_found),
    .snoop_data  (snoop_data),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rdy     (mem_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic await_snoop(input string tag);
    int unsigned n = 0;
    while ((snoop_req == '0) && (n < 20)) begin
      tick();
      n++;
    end
    check({tag, "_snoop_seen"}, 32'(snoop_req != '0), 32'd1);
  endtask

  // Serve one read miss from memory with no snoop hit and immediate mem_rdy.
  task automatic serve_miss(input int unsigned core, input logic [AW-1:0] addr,
                            input logic [DW-1:0] rdata, input string tag);
    logic [N-1:0] me;
    logic [N-1:0] others;
    me       = '0;
    me[core] = 1'b1;
    others   = ~me;
    await_snoop(tag);
    check({tag, "_sreq"}, 32'(snoop_req), 32'(others));
    check({tag, "_sop"}, 32'(snoop_op), 32'd0);
    check({tag, "_saddr"}, 32'(snoop_addr), 32'(addr));
    tick();
    snoop_found = '0;
    tick();
    check({tag, "_mem_re"}, 32'(mem_re), 32'd1);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
    mem_rdy   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_rdy = 1'b0;
    check({tag, "_done"}, 32'(core_done), 32'(me));
    check({tag, "_fill"}, 32'(fill_data), 32'(rdata));
    core_rd_miss[core] = 1'b0;
    core_wr_miss[core] = 1'b0;
    core_inv[core]     = 1'b0;
    tick();
    check({tag, "_done_clr"}, 32'(core_done), 32'd0);
  endtask

  initial begin
    int unsigned lat;
    logic        saw;

    rst          = 1'b1;
    core_rd_miss = 2'b11;
    core_wr_miss = '0;
    core_inv     = '0;
    core_addr    = {13'h00AA, 13'h0055};
    snoop_found  = '0;
    snoop_data   = '0;
    mem_rdata    = '0;
    mem_rdy      = 1'b0;

    // 1: reset with requests pending
    tick();
    tick();
    check("rst_done", 32'(core_done), 32'd0);
    check("rst_sreq", 32'(snoop_req), 32'd0);
    check("rst_mem", 32'({mem_re, mem_we}), 32'd0);
    check("rst_fill", 32'(fill_data), 32'd0);
    check("rst_addr", 32'(mem_addr | snoop_addr), 32'd0);
    rst = 1'b0;
    tick();
    check("t1_no_snoop_c1", 32'(snoop_req), 32'd0);
    tick();
    check("t1_snoop_c2", 32'(snoop_req), 32'b10);

    // 5: both pending -> core0, core1; repeat -> core0, core1
    serve_miss(0, 13'h0055, 16'h1111, "t5a_c0");
    serve_miss(1, 13'h00AA, 16'h2222, "t5a_c1");
    core_rd_miss = 2'b11;
    serve_miss(0, 13'h0055, 16'h3333, "t5b_c0");
    serve_miss(1, 13'h00AA, 16'h4444, "t5b_c1");
    tick();

    // 2: core0 read miss, memory answers 3 cycles after mem_re
    core_addr[AW-1:0] = 13'h0104;
    core_rd_miss      = 2'b01;
    await_snoop("t2");
    check("t2_sreq", 32'(snoop_req), 32'b10);
    check("t2_sop", 32'(snoop_op), 32'd0);
    check("t2_saddr", 32'(snoop_addr), 32'h0104);
    tick();
    tick();
    check("t2_mem_re", 32'(mem_re), 32'd1);
    check("t2_mem_addr", 32'(mem_addr), 32'h0104);
    check("t2_no_we", 32'(mem_we), 32'd0);
    tick();
    tick();
    tick();
    check("t2_mem_re_held", 32'(mem_re), 32'd1);
    check("t2_no_done_early", 32'(core_done), 32'd0);
    mem_rdy   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_rdy   = 1'b0;
    mem_rdata = '0;
    check("t2_done", 32'(core_done), 32'b01);
    check("t2_fill", 32'(fill_data), 32'hBEEF);
    core_rd_miss = '0;
    tick();
    tick();

    // 3: core1 write miss, core0 owns the line; stray mem_rdy ignored
    core_addr[2*AW-1:AW] = 13'h0200;
    core_wr_miss         = 2'b10;
    lat = 1;
    saw = 1'b0;
    tick();
    lat++;
    saw = saw | mem_re | mem_we;
    check("t3_sreq", 32'(snoop_req), 32'b01);
    check("t3_sop", 32'(snoop_op), 32'd1);
    check("t3_saddr", 32'(snoop_addr), 32'h0200);
    tick();
    lat++;
    saw = saw | mem_re | mem_we;
    snoop_found           = 2'b01;
    snoop_data[DW-1:0]    = 16'h1234;
    mem_rdy               = 1'b1;
    tick();
    lat++;
    saw = saw | mem_re | mem_we;
    snoop_found = '0;
    snoop_data  = '0;
    mem_rdy     = 1'b0;
    check("t3_latency", 32'(lat), 32'd4);
    check("t3_done", 32'(core_done), 32'b10);
    check("t3_fill", 32'(fill_data), 32'h1234);
    check("t3_no_mem", 32'(saw), 32'd0);
    core_wr_miss = '0;
    tick();
    tick();

    // 4: core0 read miss, core1 owns Modified -> write-back then fill
    core_addr[AW-1:0] = 13'h0300;
    core_rd_miss      = 2'b01;
    await_snoop("t4");
    check("t4_sreq", 32'(snoop_req), 32'b10);
    tick();
    snoop_found = 2'b10;
    snoop_data  = {16'h5A5A, 16'hFFFF};
    tick();
    snoop_found = '0;
    snoop_data  = '0;
    check("t4_mem_we", 32'(mem_we), 32'd1);
    check("t4_no_re", 32'(mem_re), 32'd0);
    check("t4_mem_addr", 32'(mem_addr), 32'h0300);
    check("t4_wdata", 32'(mem_wdata), 32'h5A5A);
    tick();
    check("t4_we_held", 32'(mem_we), 32'd1);
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    check("t4_done", 32'(core_done), 32'b01);
    check("t4_fill", 32'(fill_data), 32'h5A5A);
    core_rd_miss = '0;
    tick();
    tick();

    // 6a: core1 upgrade, no memory access
    core_addr[2*AW-1:AW] = 13'h0400;
    core_inv             = 2'b10;
    await_snoop("t6");
    check("t6_sreq", 32'(snoop_req), 32'b01);
    check("t6_sop", 32'(snoop_op), 32'd2);
    check("t6_saddr", 32'(snoop_addr), 32'h0400);
    tick();
    snoop_found        = 2'b01;
    snoop_data[DW-1:0] = 16'h7777;
    tick();
    snoop_found = '0;
    snoop_data  = '0;
    check("t6_done", 32'(core_done), 32'b10);
    check("t6_no_mem", 32'({mem_re, mem_we}), 32'd0);
    core_inv = '0;
    tick();
    tick();

    // 6b: reset during MEM_RD aborts without core_done
    core_addr[AW-1:0] = 13'h0500;
    core_rd_miss      = 2'b01;
    await_snoop("t6r");
    tick();
    tick();
    check("t6r_mem_re", 32'(mem_re), 32'd1);
    rst = 1'b1;
    tick();
    check("t6r_re_drop", 32'(mem_re), 32'd0);
    check("t6r_no_done", 32'(core_done), 32'd0);
    mem_rdy = 1'b1;
    tick();
    rst          = 1'b0;
    mem_rdy      = 1'b0;
    core_rd_miss = '0;
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      saw = saw | (|core_done) | mem_re;
      tick();
    end
    check("t6r_quiet_after", 32'(saw), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
